ternary_vec_loader: RTL and testbench

TERNARY_VEC_LOADER -- requirements
Module: ternary_vec_loader

---
 rtl/ternary_vec_loader_pkg.sv | 26 ++
 rtl/ternary_vec_loader_if.sv | 11 +
 rtl/ternary_byte_packer.sv | 72 +++++++
 rtl/ternary_vec_loader.sv | 118 +++++++++++
 tb/tb_ternary_vec_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ternary_vec_loader_pkg.sv
// Shared definitions for the ternary vector loader: FSM state encoding,
// ternary weight codes and default geometry.
package ternary_vec_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_X = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_ILL  = 2'b10;
  localparam logic [1:0] W_NEG  = 2'b11;

  localparam int DEF_IN_LEN    = 14;
  localparam int DEF_OUT_LEN   = 7;
  localparam int DEF_BIT_WIDTH = 8;

  // Number of stream bytes needed to fill a weight bank of wbits bits.
  function automatic int weight_bytes(input int wbits);
    return (wbits + 7) / 8;
  endfunction

endpackage

// File: rtl/ternary_vec_loader_if.sv
// Byte-stream handshake between a data source and the ternary vector loader.
interface ternary_vec_loader_if;

  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);

endinterface

// File: rtl/ternary_byte_packer.sv
// Packs accepted weight bytes LSB-first into the ternary weight bank.
// Optional code checking is enabled by defining TERNARY_CODE_CHECK_EN.
module ternary_byte_packer
  import ternary_vec_loader_pkg::*;
#(
  parameter int WBits = 2 * DEF_IN_LEN * DEF_OUT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [7:0]       byte_in,
  output logic [WBits-1:0] w,
  output logic             last,
  output logic             err
);

  localparam int NBytes = weight_bytes(WBits);
  localparam int IW     = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [IW-1:0] idx;
  logic [7:0]    wr_byte;

  function automatic logic [7:0] sanitize(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    for (int c = 0; c < 4; c++) begin
      if (b[2*c +: 2] == W_ILL) r[2*c +: 2] = W_ZERO;
    end
    return r;
  endfunction

  function automatic logic has_ill(input logic [7:0] b);
    logic f;
    f = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (b[2*c +: 2] == W_ILL) f = 1'b1;
    end
    return f;
  endfunction

`ifdef TERNARY_CODE_CHECK_EN
  assign wr_byte = sanitize(byte_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (en && wr && has_ill(byte_in)) begin
      err <= 1'b1;
    end
  end
`else
  assign wr_byte = byte_in;
  assign err     = 1'b0;
`endif

  assign last = wr && (idx == IW'(NBytes - 1));

  // Bits of the final byte that fall past the bank width are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      w   <= '0;
    end else if (en && wr) begin
      idx <= last ? '0 : idx + 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (int'(idx) * 8 + i < WBits) w[int'(idx) * 8 + i] <= wr_byte[i];
      end
    end
  end

endmodule

// File: rtl/ternary_vec_loader.sv
// Loads a ternary weight bank and an activation vector from a byte stream,
// then streams activation pairs row by row to a downstream multiplier.
module ternary_vec_loader
  import ternary_vec_loader_pkg::*;
#(
  parameter int InLen    = DEF_IN_LEN,
  parameter int OutLen   = DEF_OUT_LEN,
  parameter int BitWidth = DEF_BIT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        start,
  input  logic                        load_w,
  ternary_vec_loader_if.slave         bus,
  output logic [2*InLen*OutLen-1:0]   W,
  output logic [2:0]                  row,
  output logic [2*BitWidth-1:0]       VecIn,
  output logic                        mult_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err_code
);

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD_W = 2'(ST_LOAD_W);
  localparam logic [1:0] S_LOAD_X = 2'(ST_LOAD_X);
  localparam logic [1:0] S_RUN    = 2'(ST_RUN);

  localparam int XW   = (InLen > 1) ? $clog2(InLen) : 1;
  localparam int Rows = InLen / 2;

  logic [1:0]          state;
  logic [XW-1:0]       x_cnt;
  logic [BitWidth-1:0] x     [InLen];
  logic [BitWidth-1:0] x_nxt [InLen];

  logic acc_w, acc_x, last_w, last_x, pk_err;
  int   pair_lo;

  assign bus.data_ready = en && (state == S_LOAD_W || state == S_LOAD_X);
  assign acc_w          = bus.data_valid && bus.data_ready && (state == S_LOAD_W);
  assign acc_x          = bus.data_valid && bus.data_ready && (state == S_LOAD_X);
  assign last_x         = acc_x && (x_cnt == XW'(InLen - 1));

  assign mult_en  = en && (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign err_code = pk_err;

  ternary_byte_packer #(
    .WBits (2 * InLen * OutLen)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr      (acc_w),
    .byte_in (bus.data_in),
    .w       (W),
    .last    (last_w),
    .err     (pk_err)
  );

  // Buffer view including the byte accepted this cycle, so the first pair
  // can be presented on the edge that accepts the final activation.
  always_comb begin
    x_nxt = x;
    if (acc_x) x_nxt[x_cnt] = BitWidth'(bus.data_in);
  end

  always_comb begin
    pair_lo = 0;
    if (int'(row) < Rows - 1) pair_lo = 2 * (int'(row) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      x_cnt <= '0;
      row   <= '0;
      VecIn <= '0;
      done  <= 1'b0;
      for (int i = 0; i < InLen; i++) x[i] <= '0;
    end else if (en) begin
      done <= 1'b0;
      if (acc_x) x[x_cnt] <= BitWidth'(bus.data_in);
      case (state)
        S_IDLE: begin
          if (start) state <= load_w ? S_LOAD_W : S_LOAD_X;
        end
        S_LOAD_W: begin
          if (last_w) state <= S_LOAD_X;
        end
        S_LOAD_X: begin
          if (last_x) begin
            x_cnt <= '0;
            state <= S_RUN;
            row   <= '0;
            VecIn <= {x_nxt[1], x_nxt[0]};
          end else if (acc_x) begin
            x_cnt <= x_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (row == 3'(Rows - 1)) begin
            state <= S_IDLE;
            row   <= '0;
            done  <= 1'b1;
          end else begin
            row   <= row + 1'b1;
            VecIn <= {x[pair_lo + 1], x[pair_lo]};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_vec_loader.sv
// Randomized scoreboard bench for ternary_vec_loader against a byte-level model.
module tb_ternary_vec_loader;

  localparam int InLen  = 14;
  localparam int OutLen = 7;
  localparam int BW     = 8;
  localparam int WW     = 2 * InLen * OutLen;
  localparam int NB     = (WW + 7) / 8;
  localparam int ROWS   = InLen / 2;

  typedef struct {
    bit          is_done;
    logic [2:0]  row;
    logic [15:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, start, load_w;
  logic [WW-1:0]   W;
  logic [2:0]      row;
  logic [2*BW-1:0] VecIn;
  logic mult_en, busy, done, err_code;

  ternary_vec_loader_if bus ();

  ternary_vec_loader #(.InLen(InLen), .OutLen(OutLen), .BitWidth(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .load_w   (load_w),
    .bus      (bus),
    .W        (W),
    .row      (row),
    .VecIn    (VecIn),
    .mult_en  (mult_en),
    .busy     (busy),
    .done     (done),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  logic [WW-1:0] mw;
  logic          merr;
  logic [7:0]    wb [NB];
  logic [7:0]    xb [InLen];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  // Model of one accepted weight byte: lands at bit 8k, illegal codes
  // cleaned and flagged when checking is built in.
  task automatic model_w(input int k, input logic [7:0] b);
    logic [7:0] s;
    s = b;
`ifdef TERNARY_CODE_CHECK_EN
    for (int c = 0; c < 4; c++) begin
      if (b[2*c +: 2] == 2'b10) begin
        s[2*c +: 2] = 2'b00;
        merr = 1'b1;
      end
    end
`endif
    for (int i = 0; i < 8; i++) begin
      if (8*k + i < WW) mw[8*k + i] = s[i];
    end
  endtask

  // Monitor: pops expected RUN rows and the done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (!en) begin
        checks++;
        if (mult_en) begin
          errors++;
          $display("FAIL mult_en_frozen got 1 expected 0");
        end
      end else begin
        if (mult_en) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL run_unexpected row %0d vec %0h", row, VecIn);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (e.is_done || row !== e.row || VecIn !== e.vec) begin
              errors++;
              $display("FAIL run_row got row %0d vec %0h done_exp %0d expected row %0d vec %0h",
                       row, VecIn, e.is_done, e.row, e.vec);
            end
          end
        end
        if (done) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected got done=1 expected 0");
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (!e.is_done) begin
              errors++;
              $display("FAIL done_early got done at row slot %0d expected row %0d", row, e.row);
            end
          end
        end
      end
    end
  end

  task automatic start_job(input logic lw);
    start = 1'b1;
    load_w = lw;
    bus.data_valid = 1'b1;
    bus.data_in = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0;
    bus.data_valid = 1'b0;
  endtask

  task automatic feed(input bit is_w, input int n, input bit gap);
    int k, cyc;
    logic rdy, vld;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 1000) begin
      bus.data_valid = gap ? (cyc % 2 == 0) : 1'b1;
      bus.data_in = is_w ? wb[k] : xb[k];
      @(negedge clk);
      rdy = bus.data_ready;
      vld = bus.data_valid;
      @(posedge clk); #1;
      if (rdy && vld) begin
        if (is_w) model_w(k, wb[k]);
        k++;
      end
      cyc++;
    end
    bus.data_valid = 1'b0;
    if (k < n) begin
      errors++;
      $display("FAIL feed_timeout got %0d bytes expected %0d", k, n);
    end
  endtask

  task automatic push_run();
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      e.is_done = 1'b0;
      e.row = 3'(r);
      e.vec = {xb[2*r+1], xb[2*r]};
      sbq.push_back(e);
    end
    e.is_done = 1'b1;
    e.row = 3'd0;
    e.vec = 16'h0;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input bit poke);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      if (poke && n == 1) begin
        start = 1'b1;
        load_w = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL job_timeout got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    check("busy_after_job", WW'(busy), WW'(0));
    check("w_bank", W, mw);
    check("err_code", WW'(err_code), WW'(merr));
  endtask

  // mode: 0 fixed REQ pattern, 1 random, 2 weights untouched F0.. activations
  task automatic run_job(input logic lw, input int mode, input bit gap, input bit freeze, input bit poke);
    for (int k = 0; k < NB; k++) wb[k] = (mode == 0) ? 8'h55 : 8'($urandom_range(0, 255));
    for (int i = 0; i < InLen; i++) begin
      if (mode == 0)      xb[i] = 8'(i + 1);
      else if (mode == 2) xb[i] = 8'(8'hF0 + i);
      else                xb[i] = 8'($urandom_range(0, 255));
    end
    push_run();
    start_job(lw);
    if (lw) feed(1'b1, NB, gap);
    feed(1'b0, InLen, gap);
    if (freeze) begin
      int n;
      n = 0;
      while (!(mult_en && row == 3'd3) && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("freeze_row", WW'(row), WW'(3));
        check("freeze_vec", WW'(VecIn), WW'({xb[7], xb[6]}));
        @(posedge clk); #1;
      end
      en = 1'b1;
    end
    wait_done(poke);
  endtask

  task automatic check_reset_state();
    check("rst_busy", WW'(busy), WW'(0));
    check("rst_w", W, '0);
    check("rst_row", WW'(row), WW'(0));
    check("rst_vec", WW'(VecIn), WW'(0));
    check("rst_mult_en", WW'(mult_en), WW'(0));
    check("rst_ready", WW'(bus.data_ready), WW'(0));
    check("rst_done", WW'(done), WW'(0));
    check("rst_err", WW'(err_code), WW'(0));
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    load_w = 1'b0;
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    mw = '0;
    merr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    run_job(1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("w_all_pos", W, {(WW/2){2'b01}});
    run_job(1'b0, 2, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 1, 1'b1, 1'b0, 1'b0);
    run_job(1'b0, 1, 1'b0, 1'b1, 1'b0);
    run_job(1'b1, 1, 1'b0, 1'b0, 1'b1);

    // Abandon a weight load part-way through.
    for (int k = 0; k < NB; k++) wb[k] = 8'($urandom_range(0, 255));
    wb[0] = 8'hAA;
    start_job(1'b1);
    feed(1'b1, 10, 1'b0);
    check("partial_w", W, mw);
    check("partial_err", WW'(err_code), WW'(merr));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mw = '0;
    merr = 1'b0;
    check_reset_state();
    repeat (5) @(posedge clk);
    #1;
    run_job(1'b0, 1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
